// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the memory arbiter slice.
//   ADDR_W / DATA_W : memory word address and data widths.
//   state_t         : arbiter FSM state encoding (IDLE, ACC, ACK).
//   OWNER_CPU/LDR   : values carried on the arbiter's owner output.
package cpu_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_LDR = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2 -- two-way winner selection between CPU and program loader.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset.
//   cpu_req   : CPU is requesting.
//   ldr_req   : loader is requesting.
//   grant     : a winner is being taken this cycle (updates the pointer).
//   win_ldr   : 1 = loader wins, 0 = CPU wins (only meaningful with a request).
// Configuration macro LDR_PRIORITY_EN: when defined, the loader always wins
// a tie and no round-robin pointer exists; otherwise two-way round-robin.
module rr_pick2 (
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic ldr_req,
  input  logic grant,
  output logic win_ldr
);

`ifdef LDR_PRIORITY_EN
  // Fixed priority: state-free, so the clock, reset and grant go unused.
  logic unused_ok;
  assign unused_ok = ^{clk, rst, cpu_req, grant};
  assign win_ldr   = ldr_req;
`else
  // prefer_ldr = 1 means the CPU was granted last, so the loader wins a tie.
  // Reset leaves it 0 so the CPU wins the first tie.
  logic prefer_ldr;

  assign win_ldr = ldr_req & (~cpu_req | prefer_ldr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prefer_ldr <= 1'b0;
    end else if (grant) begin
      prefer_ldr <= ~win_ldr;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one synchronous single-port memory between the CPU
// controller and the program loader.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset.
//   cpu_req/we/addr/wdata       : CPU request (held until cpu_ack).
//   cpu_ack, cpu_rdata          : CPU completion pulse and read data.
//   ldr_req/we/addr/wdata       : loader request (held until ldr_ack).
//   ldr_ack, ldr_rdata          : loader completion pulse and read data.
//   mem_en/we/addr/wdata        : memory access strobe, write enable, address, data.
//   mem_rdata                   : memory read data, valid the cycle after mem_en.
//   owner                       : 0 = CPU, 1 = loader; last or current grant.
// Configuration macro LDR_PRIORITY_EN (handled in rr_pick2): loader wins ties.
//
// Handshake: a requester raises req with we/addr/wdata and holds them until
// its ack; ack is a single-cycle pulse and rdata is valid only during it.
// The winner's fields are captured in IDLE, so later input changes (including
// dropping req) do not affect the in-flight access, which always completes.
module mem_arbiter
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
);

  state_t state, state_nxt;

  logic              grant;
  logic              win_ldr;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic              owner_q;
  logic              ack_pulse;

  // A new grant is only taken in IDLE, so a requester still holding req in
  // its ACK cycle waits for the following IDLE and the round-robin decision.
  assign grant = (state == ST_IDLE) && (cpu_req || ldr_req);

  rr_pick2 u_pick (
    .clk     (clk),
    .rst     (rst),
    .cpu_req (cpu_req),
    .ldr_req (ldr_req),
    .grant   (grant),
    .win_ldr (win_ldr)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cpu_req || ldr_req) state_nxt = ST_ACC;
      ST_ACC:  state_nxt = ST_ACK;
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Capture of the winning request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      owner_q   <= OWNER_CPU;
    end else if (grant) begin
      cap_we    <= win_ldr ? ldr_we    : cpu_we;
      cap_addr  <= win_ldr ? ldr_addr  : cpu_addr;
      cap_wdata <= win_ldr ? ldr_wdata : cpu_wdata;
      owner_q   <= win_ldr ? OWNER_LDR : OWNER_CPU;
    end
  end

  // Output logic. The memory's own output register supplies the read data
  // in the ACK cycle; it is steered to the owner only while its ack is high.
  always_comb begin
    mem_en    = (state == ST_ACC);
    mem_we    = (state == ST_ACC) && cap_we;
    mem_addr  = cap_addr;
    mem_wdata = cap_wdata;
    ack_pulse = (state == ST_ACK);
    cpu_ack   = ack_pulse && (owner_q == OWNER_CPU);
    ldr_ack   = ack_pulse && (owner_q == OWNER_LDR);
    cpu_rdata = cpu_ack ? mem_rdata : '0;
    ldr_rdata = ldr_ack ? mem_rdata : '0;
    owner     = owner_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- self-checking bench for mem_arbiter.
// Honours LDR_PRIORITY_EN the same way as the design build.
module tb_mem_arbiter;

  logic       clk;
  logic       rst;
  logic       cpu_req, cpu_we;
  logic [4:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic       ldr_req, ldr_we;
  logic [4:0] ldr_addr;
  logic [7:0] ldr_wdata;
  logic       ldr_ack;
  logic [7:0] ldr_rdata;
  logic       mem_en, mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       owner;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Memory contents seen by the design (written from its mem_* outputs)
  // and the contents the reference model believes are there.
  logic [7:0] tb_mem  [32];
  logic [7:0] ref_mem [32];

  // Reference arbiter state: who was granted most recently.
  bit last_ldr;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .ldr_req   (ldr_req),
    .ldr_we    (ldr_we),
    .ldr_addr  (ldr_addr),
    .ldr_wdata (ldr_wdata),
    .ldr_ack   (ldr_ack),
    .ldr_rdata (ldr_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .owner     (owner)
  );

  // Clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_mem_en"},    32'(mem_en),    0);
    chk({pfx, "_mem_we"},    32'(mem_we),    0);
    chk({pfx, "_mem_addr"},  32'(mem_addr),  0);
    chk({pfx, "_mem_wdata"}, 32'(mem_wdata), 0);
    chk({pfx, "_cpu_ack"},   32'(cpu_ack),   0);
    chk({pfx, "_cpu_rdata"}, 32'(cpu_rdata), 0);
    chk({pfx, "_ldr_ack"},   32'(ldr_ack),   0);
    chk({pfx, "_ldr_rdata"}, 32'(ldr_rdata), 0);
    chk({pfx, "_owner"},     32'(owner),     0);
  endtask

  // Arbitration rule: a lone requester wins; on a tie the one not granted
  // last wins (or always the loader under fixed priority).
  function automatic bit model_pick_ldr(input bit c, input bit l);
    bit r;
    if (c && l) begin
`ifdef LDR_PRIORITY_EN
      r = 1'b1;
`else
      r = !last_ldr;
`endif
    end else begin
      r = l;
    end
    return r;
  endfunction

  // Reset: the next tie goes to the CPU.
  task automatic model_reset();
    last_ldr = 1'b1;
  endtask

  // Driver: the request inputs are already set at a falling edge with the
  // arbiter in IDLE. Runs one full access (grant, ACC, ACK, back to IDLE),
  // emulating the synchronous memory and checking every cycle.
  task automatic access(input bit keep, input bit early_drop, input bit perturb,
                        input logic [4:0] new_addr, output int ack_cyc);
    bit         ex_ldr;
    logic       ex_we;
    logic [4:0] ex_addr;
    logic [7:0] ex_wd, ex_rd, pend;
    ex_ldr  = model_pick_ldr(cpu_req, ldr_req);
    ex_we   = ex_ldr ? ldr_we    : cpu_we;
    ex_addr = ex_ldr ? ldr_addr  : cpu_addr;
    ex_wd   = ex_ldr ? ldr_wdata : cpu_wdata;
    ex_rd   = ref_mem[ex_addr];
    last_ldr = ex_ldr;
    if (ex_we) ref_mem[ex_addr] = ex_wd;

    @(posedge clk); @(negedge clk);
    // ACC cycle
    chk("acc_mem_en",    32'(mem_en),    1);
    chk("acc_mem_we",    32'(mem_we),    32'(ex_we));
    chk("acc_mem_addr",  32'(mem_addr),  32'(ex_addr));
    chk("acc_mem_wdata", 32'(mem_wdata), 32'(ex_wd));
    chk("acc_owner",     32'(owner),     32'(ex_ldr));
    chk("acc_cpu_ack",   32'(cpu_ack),   0);
    chk("acc_ldr_ack",   32'(ldr_ack),   0);
    chk("acc_cpu_rdata", 32'(cpu_rdata), 0);
    chk("acc_ldr_rdata", 32'(ldr_rdata), 0);
    pend = 8'($urandom);
    if (mem_en) begin
      if (mem_we) tb_mem[mem_addr] = mem_wdata;
      else        pend = tb_mem[mem_addr];
    end
    if (early_drop) begin
      if (ex_ldr) ldr_req = 1'b0; else cpu_req = 1'b0;
    end
    if (perturb) begin
      if (ex_ldr) begin
        ldr_addr = new_addr; ldr_wdata = 8'($urandom); ldr_we = ~ldr_we;
      end else begin
        cpu_addr = new_addr; cpu_wdata = 8'($urandom); cpu_we = ~cpu_we;
      end
    end

    @(posedge clk);
    #1 mem_rdata = pend;
    @(negedge clk);
    // ACK cycle
    chk("ack_mem_en",    32'(mem_en),    0);
    chk("ack_mem_we",    32'(mem_we),    0);
    chk("ack_mem_addr",  32'(mem_addr),  32'(ex_addr));
    chk("ack_mem_wdata", 32'(mem_wdata), 32'(ex_wd));
    chk("ack_owner",     32'(owner),     32'(ex_ldr));
    chk("ack_cpu_ack",   32'(cpu_ack),   32'(!ex_ldr));
    chk("ack_ldr_ack",   32'(ldr_ack),   32'(ex_ldr));
    if (ex_ldr) begin
      chk("ack_cpu_rdata_idle", 32'(cpu_rdata), 0);
      if (!ex_we) chk("ack_ldr_rdata", 32'(ldr_rdata), 32'(ex_rd));
    end else begin
      chk("ack_ldr_rdata_idle", 32'(ldr_rdata), 0);
      if (!ex_we) chk("ack_cpu_rdata", 32'(cpu_rdata), 32'(ex_rd));
    end
    ack_cyc = cyc;
    if (!keep) begin
      if (ex_ldr) ldr_req = 1'b0; else cpu_req = 1'b0;
    end

    @(posedge clk);
    #1 mem_rdata = 8'($urandom);
    @(negedge clk);
    // Back in IDLE: no regrant in the ACK cycle, so no strobe here.
    chk("idle_mem_en",    32'(mem_en),    0);
    chk("idle_cpu_ack",   32'(cpu_ack),   0);
    chk("idle_ldr_ack",   32'(ldr_ack),   0);
    chk("idle_cpu_rdata", 32'(cpu_rdata), 0);
    chk("idle_ldr_rdata", 32'(ldr_rdata), 0);
    chk("idle_mem_addr",  32'(mem_addr),  32'(ex_addr));
    chk("idle_owner",     32'(owner),     32'(ex_ldr));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int t0, ac;
    logic exp_own [4];

    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
    mem_rdata = 8'h00;
    for (int i = 0; i < 32; i++) begin
      tb_mem[i]  = 8'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[3] = 8'hA5; ref_mem[3] = 8'hA5;
    model_reset();

    // Reset state
    @(negedge clk); @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("post_reset_idle");

    // Single CPU read of address 03
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'h03;
    t0 = cyc;
    access(0, 0, 0, 5'h00, ac);
    chk("cpu_read_ack_latency", 32'(ac - t0), 2);

    // Loader write 3C to 1F, then CPU reads it back
    ldr_req = 1; ldr_we = 1; ldr_addr = 5'h1F; ldr_wdata = 8'h3C;
    access(0, 0, 0, 5'h00, ac);
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'h1F;
    access(0, 0, 0, 5'h00, ac);

    // Input change mid-access: address 04 moved to 09 during ACC
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'h04;
    access(0, 0, 1, 5'h09, ac);

    // Contention from a fresh reset: four accesses with both held high
    pulse_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'h0A;
    ldr_req = 1; ldr_we = 1; ldr_addr = 5'h0B; ldr_wdata = 8'h5E;
`ifdef LDR_PRIORITY_EN
    exp_own = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
    exp_own = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      access(1, 0, 0, 5'h00, ac);
      chk($sformatf("contend_owner_%0d", i), 32'(owner), 32'(exp_own[i]));
      chk($sformatf("contend_ack_cycle_%0d", i), 32'(ac - t0), 32'(2 + 3 * i));
    end
    cpu_req = 0; ldr_req = 0;
    @(negedge clk);

    // Reset during ACC: outputs clear at once, no ack, reissued request completes
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'h07;
    @(posedge clk); @(negedge clk);
    chk("rst_acc_mem_en_before", 32'(mem_en), 1);
    rst = 1'b1;
    #1;
    chk_all_zero("rst_in_acc");
    @(posedge clk); @(negedge clk);
    chk_all_zero("rst_held");
    rst = 1'b0;
    model_reset();
    t0 = cyc;
    access(0, 0, 0, 5'h00, ac);
    chk("rst_reissue_ack_latency", 32'(ac - t0), 2);

    // Randomized traffic against the reference model
    for (int n = 0; n < 24; n++) begin
      if (!cpu_req && $urandom_range(0, 1) == 1) begin
        cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 5'($urandom); cpu_wdata = 8'($urandom);
      end
      if (!ldr_req && $urandom_range(0, 1) == 1) begin
        ldr_req = 1; ldr_we = 1'($urandom_range(0, 1));
        ldr_addr = 5'($urandom); ldr_wdata = 8'($urandom);
      end
      if (!cpu_req && !ldr_req) begin
        cpu_req = 1; cpu_we = 0; cpu_addr = 5'($urandom);
      end
      access(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom), ac);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
